// File: rtl/axis256_to_512.sv
// -----------------------------------------------------------------------------
// axis256_to_512
//
// Packs pairs of 256-bit AXI-Stream beats into single 512-bit output beats.
// A small FSM tracks whether one half is parked in the hold register.
// When the second half arrives, the two halves are combined into the
// registered output stage.
//
// Ordering is set by LOW_FIRST:
//   1 : the first accepted beat of a pair lands in AXIS_TX_TDATA[255:0]
//   0 : the first accepted beat of a pair lands in AXIS_TX_TDATA[511:256]
//
// Optional feature macro: AXIS_TLAST_EN
//   When defined, the TLAST sideband ports exist.
//   A beat accepted while no half is held, and that carries TLAST, is flushed
//   on its own: it sits in its LOW_FIRST position, the other half is zero,
//   and TX_TLAST is set.
//   A completed pair takes TX_TLAST from the second beat.
//
// Ports:
//   clk             in   sole clock, rising edge
//   reset           in   synchronous active-high reset
//   AXIS_RX_TDATA   in   256-bit input data
//   AXIS_RX_TVALID  in   input beat valid
//   AXIS_RX_TREADY  out  input beat accepted (independent of RX valid/data)
//   AXIS_RX_TLAST   in   input packet end            (AXIS_TLAST_EN only)
//   AXIS_TX_TLAST   out  output packet end, reg'd    (AXIS_TLAST_EN only)
//   AXIS_TX_TDATA   out  512-bit packed data, registered
//   AXIS_TX_TVALID  out  output beat valid, registered
//   AXIS_TX_TREADY  in   downstream accepts output beat
// -----------------------------------------------------------------------------
module axis256_to_512 #(
    parameter int LOW_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] AXIS_RX_TDATA,
    input  logic         AXIS_RX_TVALID,
    output logic         AXIS_RX_TREADY,
`ifdef AXIS_TLAST_EN
    input  logic         AXIS_RX_TLAST,
    output logic         AXIS_TX_TLAST,
`endif
    output logic [511:0] AXIS_TX_TDATA,
    output logic         AXIS_TX_TVALID,
    input  logic         AXIS_TX_TREADY
);

    // FSM encoding: FLUSH exists only when packet boundaries are supported.
`ifdef AXIS_TLAST_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1
    } state_t;
`endif

    // Combine the held (first) half with the newly accepted (second) half.
    function automatic logic [511:0] pack_pair(input logic [255:0] first_half,
                                               input logic [255:0] second_half);
        logic [511:0] packed_v;
        if (LOW_FIRST != 0) begin
            packed_v = {second_half, first_half};
        end else begin
            packed_v = {first_half, second_half};
        end
        return packed_v;
    endfunction

    // Place a lone half in its first-beat position, zero-filling the other.
    function automatic logic [511:0] pack_single(input logic [255:0] first_half);
        logic [511:0] packed_v;
        if (LOW_FIRST != 0) begin
            packed_v = {256'd0, first_half};
        end else begin
            packed_v = {first_half, 256'd0};
        end
        return packed_v;
    endfunction

    state_t       state_r;
    state_t       state_next_s;
    logic [255:0] hold_r;
    logic         out_valid_r;
    logic [511:0] tx_data_r;
    logic         rx_ready_s;
    logic         out_free_s;
    logic         tx_fire_s;
    logic         hold_load_s;
    logic         load_pair_s;
    logic         load_flush_s;
`ifdef AXIS_TLAST_EN
    logic         tx_last_r;
`endif

    // The output slot can take new data when it is empty,
    // or when it is being drained in this same cycle.
    assign out_free_s = ~out_valid_r | AXIS_TX_TREADY;
    assign tx_fire_s  = out_valid_r & AXIS_TX_TREADY;

    // Next-state and handshake decode; RX ready never looks at RX valid/data.
    always_comb begin
        state_next_s = state_r;
        rx_ready_s   = 1'b0;
        hold_load_s  = 1'b0;
        load_pair_s  = 1'b0;
        load_flush_s = 1'b0;
        if (reset) begin
            rx_ready_s   = 1'b0;
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    rx_ready_s = 1'b1;
                    if (AXIS_RX_TVALID) begin
                        hold_load_s = 1'b1;
`ifdef AXIS_TLAST_EN
                        if (AXIS_RX_TLAST) begin
                            state_next_s = ST_FLUSH;
                        end else begin
                            state_next_s = ST_HALF;
                        end
`else
                        state_next_s = ST_HALF;
`endif
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    rx_ready_s = out_free_s;
                    if (out_free_s && AXIS_RX_TVALID) begin
                        load_pair_s  = 1'b1;
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_HALF;
                    end
                end
`ifdef AXIS_TLAST_EN
                ST_FLUSH: begin
                    // Lone half waits here for the output slot; input is held off.
                    rx_ready_s = 1'b0;
                    if (out_free_s) begin
                        load_flush_s = 1'b1;
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_FLUSH;
                    end
                end
`endif
                default: begin
                    rx_ready_s   = 1'b0;
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Hold register for the first half of a pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= 256'd0;
        end else if (hold_load_s) begin
            hold_r <= AXIS_RX_TDATA;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Output data register: changes only when a pair or a flush loads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data_r <= 512'd0;
        end else if (load_pair_s) begin
            tx_data_r <= pack_pair(hold_r, AXIS_RX_TDATA);
        end else if (load_flush_s) begin
            tx_data_r <= pack_single(hold_r);
        end else begin
            tx_data_r <= tx_data_r;
        end
    end

    // Output valid: a load in the same cycle as a drain keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (load_pair_s || load_flush_s) begin
            out_valid_r <= 1'b1;
        end else if (tx_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef AXIS_TLAST_EN
    // Output TLAST: a pair inherits the second beat's TLAST; a flush is always last.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_last_r <= 1'b0;
        end else if (load_pair_s) begin
            tx_last_r <= AXIS_RX_TLAST;
        end else if (load_flush_s) begin
            tx_last_r <= 1'b1;
        end else begin
            tx_last_r <= tx_last_r;
        end
    end

    assign AXIS_TX_TLAST = tx_last_r;
`endif

    assign AXIS_RX_TREADY = rx_ready_s;
    assign AXIS_TX_TDATA  = tx_data_r;
    assign AXIS_TX_TVALID = out_valid_r;

endmodule

// File: tb/tb_axis256_to_512.sv
// -----------------------------------------------------------------------------
// tb_axis256_to_512
//
// Scoreboard bench for axis256_to_512.
// Two instances share one stimulus stream:
//   u_dut_lo : LOW_FIRST=1
//   u_dut_hi : LOW_FIRST=0
// Expected output beats for both orderings are pushed when beats are driven.
// They are popped and compared when an output beat is accepted.
// Covers AXIS_TLAST_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_axis256_to_512;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] rx_data;
    logic         rx_valid;
    logic         tx_ready;
    logic         rx_ready_lo, rx_ready_hi;
    logic [511:0] tx_data_lo, tx_data_hi;
    logic         tx_valid_lo, tx_valid_hi;
`ifdef AXIS_TLAST_EN
    logic         rx_last;
    logic         tx_last_lo, tx_last_hi;
`endif

    always #5 clk = ~clk;

    axis256_to_512 #(.LOW_FIRST(1)) u_dut_lo (
        .clk(clk), .reset(reset),
        .AXIS_RX_TDATA(rx_data), .AXIS_RX_TVALID(rx_valid), .AXIS_RX_TREADY(rx_ready_lo),
`ifdef AXIS_TLAST_EN
        .AXIS_RX_TLAST(rx_last), .AXIS_TX_TLAST(tx_last_lo),
`endif
        .AXIS_TX_TDATA(tx_data_lo), .AXIS_TX_TVALID(tx_valid_lo), .AXIS_TX_TREADY(tx_ready)
    );

    axis256_to_512 #(.LOW_FIRST(0)) u_dut_hi (
        .clk(clk), .reset(reset),
        .AXIS_RX_TDATA(rx_data), .AXIS_RX_TVALID(rx_valid), .AXIS_RX_TREADY(rx_ready_hi),
`ifdef AXIS_TLAST_EN
        .AXIS_RX_TLAST(rx_last), .AXIS_TX_TLAST(tx_last_hi),
`endif
        .AXIS_TX_TDATA(tx_data_hi), .AXIS_TX_TVALID(tx_valid_hi), .AXIS_TX_TREADY(tx_ready)
    );

    int vec_count   = 0;
    int miscompares = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: expected beats for each ordering, plus expected TLAST.
    logic [511:0] exp_lo_q[$];
    logic [511:0] exp_hi_q[$];
    logic         exp_last_q[$];
    logic         have_half = 1'b0;
    logic [255:0] half_data = 256'd0;

    // Reference pairing model, advanced as each beat is driven.
    task automatic model_push(input logic [255:0] d, input logic last);
        if (!have_half) begin
            if (last) begin
                exp_lo_q.push_back({256'd0, d});
                exp_hi_q.push_back({d, 256'd0});
                exp_last_q.push_back(1'b1);
            end else begin
                half_data = d;
                have_half = 1'b1;
            end
        end else begin
            exp_lo_q.push_back({d, half_data});
            exp_hi_q.push_back({half_data, d});
            exp_last_q.push_back(last);
            have_half = 1'b0;
        end
    endtask

    // Offer one beat; returns at posedge+1 after it is accepted.
    // stalls = number of cycles the beat waited.
    task automatic send_beat(input logic [255:0] d, input logic last, output int stalls);
        bit accepted = 1'b0;
        model_push(d, last);
        rx_data  = d;
        rx_valid = 1'b1;
`ifdef AXIS_TLAST_EN
        rx_last  = last;
`endif
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_ready_lo) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
            stalls++;
        end
        rx_valid = 1'b0;
        if (!accepted) check("rx_accept_timeout", 512'(0), 512'(1));
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_lo_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 512'(exp_lo_q.size()), 512'(0));
    endtask

    // Output monitor: scoreboard compare on accept, stability while stalled.
    logic         stall_prev = 1'b0;
    logic [511:0] prev_data  = 512'd0;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tx_valid_hold", 512'(tx_valid_lo), 512'(1));
                check("tx_data_hold", tx_data_lo, prev_data);
            end
            if (tx_valid_lo && tx_ready) begin
                if (exp_lo_q.size() == 0) begin
                    check("tx_unexpected", 512'(1), 512'(0));
                end else begin
                    logic lst;
                    check("tx_data_low_first", tx_data_lo, exp_lo_q.pop_front());
                    check("tx_data_high_first", tx_data_hi, exp_hi_q.pop_front());
                    lst = exp_last_q.pop_front();
`ifdef AXIS_TLAST_EN
                    check("tx_last", 512'(tx_last_lo), 512'(lst));
`endif
                end
            end
            stall_prev = tx_valid_lo && !tx_ready;
            prev_data  = tx_data_lo;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int           st;
    int           total;
    logic [255:0] beat_a, beat_b;
    logic         rnd_done;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 256'd0;
        tx_ready = 1'b1;
`ifdef AXIS_TLAST_EN
        rx_last  = 1'b0;
`endif

        // ---- Reset state ----
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 512'(rx_ready_lo), 512'(0));
        check("rst_tx_valid", 512'(tx_valid_lo), 512'(0));
        check("rst_tx_data", tx_data_lo, 512'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---- Single pair, latency and one-cycle valid ----
        beat_a = {32{8'h11}};
        beat_b = {32{8'h22}};
        send_beat(beat_a, 1'b0, st);
        send_beat(beat_b, 1'b0, st);
        @(negedge clk);
        check("latency_valid", 512'(tx_valid_lo), 512'(1));
        check("pair_BA", tx_data_lo, {beat_b, beat_a});
        check("pair_AB_high_first", tx_data_hi, {beat_a, beat_b});
        @(negedge clk);
        check("valid_one_cycle", 512'(tx_valid_lo), 512'(0));
        @(posedge clk);
        #1;

        // ---- Streaming, full throughput ----
        total = 0;
        for (int i = 0; i < 8; i++) begin
            send_beat(256'(i), 1'b0, st);
            total += st;
        end
        check("stream_no_stall", 512'(total), 512'(0));
        drain("stream_drain");

        // ---- Backpressure with held output ----
        tx_ready = 1'b0;
        send_beat({64{4'hA}}, 1'b0, st);
        send_beat({64{4'hB}}, 1'b0, st);
        send_beat({64{4'hC}}, 1'b0, st);
        rx_data  = {64{4'hD}};
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rx_ready_low", 512'(rx_ready_lo), 512'(0));
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        send_beat({64{4'hD}}, 1'b0, st);
        send_beat({64{4'hE}}, 1'b0, st);
        send_beat({64{4'hF}}, 1'b0, st);
        drain("bp_drain");

        // ---- Reset while HALF and output pending ----
        tx_ready = 1'b0;
        send_beat({32{8'h31}}, 1'b0, st);
        send_beat({32{8'h32}}, 1'b0, st);
        send_beat({32{8'h33}}, 1'b0, st);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rx_ready", 512'(rx_ready_lo), 512'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        exp_lo_q.delete();
        exp_hi_q.delete();
        exp_last_q.delete();
        have_half = 1'b0;
        @(negedge clk);
        check("midrst_tx_valid", 512'(tx_valid_lo), 512'(0));
        check("midrst_tx_data", tx_data_lo, 512'd0);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        send_beat({32{8'hC0}}, 1'b0, st);
        send_beat({32{8'hD0}}, 1'b0, st);
        @(negedge clk);
        check("after_rst_DC", tx_data_lo, {{32{8'hD0}}, {32{8'hC0}}});
        @(posedge clk);
        #1;
        drain("rst_drain");

`ifdef AXIS_TLAST_EN
        // ---- Packet boundaries: lone flush, then a pair ending a packet ----
        send_beat({32{8'hE5}}, 1'b1, st);
        send_beat({32{8'hF6}}, 1'b0, st);
        send_beat({32{8'h67}}, 1'b1, st);
        drain("tlast_drain");
`endif

        // ---- Random data with random downstream backpressure ----
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send_beat({$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom}, 1'b0, st);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 tx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        tx_ready = 1'b1;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
